// File: rtl/stack_access_arbiter_if.sv
// Requester-side and stack-side signals of the stack access arbiter.
// req[i]/ack[i] form a valid/ready pair: a transfer completes on the clk edge where
// req[i] & ack[i]; op/wdata stay stable while req[i] is high, and ack never goes to an idle requester.
interface stack_access_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [1:0]        op;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_wdata;
  logic              stk_done;
  logic [DATA_W-1:0] stk_rdata;

  modport master (
    output req, op, wdata0, wdata1, stk_done, stk_rdata,
    input  ack, err, rdata, stk_push, stk_pop, stk_wdata
  );

  modport slave (
    input  req, op, wdata0, wdata1, stk_done, stk_rdata,
    output ack, err, rdata, stk_push, stk_pop, stk_wdata
  );
endinterface

// File: rtl/stack_access_arbiter.sv
// Round-robin arbiter sharing one LIFO stack datapath between two requesters,
// with occupancy tracking, overflow/underflow rejection and a completion timeout.
module stack_access_arbiter #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_access_arbiter_if.slave bus,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic              winner;
  logic              op_l;
  logic              rr;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [1:0]        ack_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;
  logic              push_r;
  logic              pop_r;
  logic [DATA_W-1:0] stk_wdata_r;

  logic              pick;
  logic              pick_op;
  logic [DATA_W-1:0] pick_wdata;
  logic              reject;

  // The rr pointer names the preferred requester; fall back to the other one.
  always_comb begin
    pick       = rr;
    if (!bus.req[rr]) pick = ~rr;
    pick_op    = bus.op[pick];
    pick_wdata = pick ? bus.wdata1 : bus.wdata0;
    reject     = (pick_op && full) || (!pick_op && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      winner      <= 1'b0;
      op_l        <= 1'b0;
      rr          <= 1'b0;
      tmo_cnt     <= '0;
      count       <= '0;
      ack_r       <= 2'b00;
      err_r       <= 1'b0;
      rdata_r     <= '0;
      push_r      <= 1'b0;
      pop_r       <= 1'b0;
      stk_wdata_r <= '0;
    end else begin
      push_r      <= 1'b0;
      pop_r       <= 1'b0;
      stk_wdata_r <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            winner <= pick;
            op_l   <= pick_op;
            if (reject) begin
              state   <= RESP;
              ack_r   <= pick ? 2'b10 : 2'b01;
              err_r   <= 1'b1;
              rdata_r <= '0;
            end else begin
              state       <= ISSUE;
              push_r      <= pick_op;
              pop_r       <= ~pick_op;
              stk_wdata_r <= pick_op ? pick_wdata : '0;
            end
          end
        end
        ISSUE: begin
          state   <= WAIT;
          tmo_cnt <= '0;
        end
        WAIT: begin
          if (bus.stk_done) begin
            state   <= RESP;
            ack_r   <= winner ? 2'b10 : 2'b01;
            err_r   <= 1'b0;
            rdata_r <= op_l ? '0 : bus.stk_rdata;
            if (op_l && !full) count <= count + CNT_W'(1);
            else if (!op_l && !empty) count <= count - CNT_W'(1);
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            // Abort without touching the occupancy: the stack never confirmed.
            state   <= RESP;
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            ack_r   <= winner ? 2'b10 : 2'b01;
            err_r   <= 1'b1;
            rdata_r <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        RESP: begin
          state   <= IDLE;
          rr      <= ~winner;
          ack_r   <= 2'b00;
          err_r   <= 1'b0;
          rdata_r <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_r;
  assign bus.err       = err_r;
  assign bus.rdata     = rdata_r;
  assign bus.stk_push  = push_r;
  assign bus.stk_pop   = pop_r;
  assign bus.stk_wdata = stk_wdata_r;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_stack_access_arbiter.sv
// Self-checking bench for stack_access_arbiter: a behavioural stack datapath model
// plus a queue-based reference of the expected stack contents.
module tb_stack_access_arbiter;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_access_arbiter_if #(.DATA_W(DATA_W)) bus ();
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             busy;
  logic [1:0]       state_dbg;

  stack_access_arbiter #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .count(count), .full(full), .empty(empty), .busy(busy), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  // ---------------- stack datapath model ----------------
  logic [DATA_W-1:0] mem_q[$];
  logic              pending;
  logic              model_done;
  logic              model_hang;
  logic              late_done;
  logic [DATA_W-1:0] pop_hold;

  assign bus.stk_done = model_done | late_done;

  // Answers each strobe with a done pulse one cycle after the strobe cycle.
  always @(negedge clk) begin
    if (rst) begin
      mem_q.delete();
      pending       = 1'b0;
      model_done    = 1'b0;
      bus.stk_rdata = '0;
    end else begin
      model_done = pending;
      if (pending) bus.stk_rdata = pop_hold;
      pending = 1'b0;
      if (!model_hang && bus.stk_push) begin
        mem_q.push_back(bus.stk_wdata);
        pending = 1'b1;
      end
      if (!model_hang && bus.stk_pop) begin
        pop_hold = (mem_q.size() != 0) ? mem_q.pop_back() : 8'hEE;
        pending  = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst        = 1'b1;
    bus.req    = 2'b00;
    bus.op     = 2'b00;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    late_done  = 1'b0;
    model_hang = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input int r, input bit push, input logic [DATA_W-1:0] d,
                      output int lat, output logic [1:0] ack_o, output logic err_o,
                      output logic [DATA_W-1:0] rd_o, output int strobes,
                      output logic [DATA_W-1:0] wd_o);
    @(negedge clk);
    bus.req[r] = 1'b1;
    bus.op[r]  = push;
    if (r == 0) bus.wdata0 = d;
    else        bus.wdata1 = d;
    lat = -1; strobes = 0; ack_o = 2'b00; err_o = 1'b0; rd_o = '0; wd_o = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.stk_push || bus.stk_pop) begin
        strobes++;
        wd_o = bus.stk_wdata;
      end
      if (bus.ack != 2'b00) begin
        lat = k; ack_o = bus.ack; err_o = bus.err; rd_o = bus.rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req[r] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req = 2'b00; bus.op = 2'b00; bus.wdata0 = '0; bus.wdata1 = '0;
    late_done = 1'b0; model_hang = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.err, bus.rdata, bus.stk_push, bus.stk_pop, bus.stk_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h push=%b pop=%b wdata=%h expected all 0",
               bus.ack, bus.err, bus.rdata, bus.stk_push, bus.stk_pop, bus.stk_wdata);
    end
    checks++;
    if ({busy, full, empty} !== 3'b001 || count !== '0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b full=%b empty=%b count=%0d expected 0 0 1 0",
               busy, full, empty, count);
    end
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_single_push();
    int lat, st; logic [1:0] a; logic e; logic [DATA_W-1:0] rd, wd;
    apply_reset();
    send(0, 1'b1, 8'hA5, lat, a, e, rd, st, wd);
    checks++;
    if (lat !== 3 || a !== 2'b01 || e !== 1'b0) begin
      errors++;
      $display("FAIL single_push_ack: got lat=%0d ack=%b err=%b expected 3 01 0", lat, a, e);
    end
    checks++;
    if (st !== 1 || wd !== 8'hA5) begin
      errors++;
      $display("FAIL single_push_strobe: got strobes=%0d wdata=%h expected 1 a5", st, wd);
    end
    checks++;
    if (count !== CNT_W'(1) || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_push_count: got count=%0d empty=%b expected 1 0", count, empty);
    end
  endtask

  task automatic test_push_pop();
    int lat, st; logic [1:0] a; logic e; logic [DATA_W-1:0] rd, wd;
    apply_reset();
    send(0, 1'b1, 8'h11, lat, a, e, rd, st, wd);
    send(0, 1'b1, 8'h22, lat, a, e, rd, st, wd);
    send(1, 1'b0, 8'h00, lat, a, e, rd, st, wd);
    checks++;
    if (rd !== 8'h22 || a !== 2'b10 || e !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL pop_first: got rdata=%h ack=%b err=%b lat=%0d expected 22 10 0 3", rd, a, e, lat);
    end
    send(1, 1'b0, 8'h00, lat, a, e, rd, st, wd);
    checks++;
    if (rd !== 8'h11 || a !== 2'b10 || e !== 1'b0) begin
      errors++;
      $display("FAIL pop_second: got rdata=%h ack=%b err=%b expected 11 10 0", rd, a, e);
    end
    checks++;
    if (count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_count: got count=%0d empty=%b expected 0 1", count, empty);
    end
  endtask

  task automatic test_underflow_overflow();
    int lat, st; logic [1:0] a; logic e; logic [DATA_W-1:0] rd, wd;
    apply_reset();
    send(0, 1'b0, 8'h00, lat, a, e, rd, st, wd);
    checks++;
    if (lat !== 1 || a !== 2'b01 || e !== 1'b1 || rd !== '0 || st !== 0) begin
      errors++;
      $display("FAIL underflow: got lat=%0d ack=%b err=%b rdata=%h strobes=%0d expected 1 01 1 00 0",
               lat, a, e, rd, st);
    end
    for (int i = 0; i < DEPTH; i++) begin
      send(1, 1'b1, DATA_W'($urandom_range(0, 255)), lat, a, e, rd, st, wd);
      checks++;
      if (e !== 1'b0 || lat !== 3 || a !== 2'b10) begin
        errors++;
        $display("FAIL fill_push_%0d: got err=%b lat=%0d ack=%b expected 0 3 10", i, e, lat, a);
      end
    end
    send(1, 1'b1, 8'h99, lat, a, e, rd, st, wd);
    checks++;
    if (lat !== 1 || e !== 1'b1 || st !== 0) begin
      errors++;
      $display("FAIL overflow: got lat=%0d err=%b strobes=%0d expected 1 1 0", lat, e, st);
    end
    checks++;
    if (count !== CNT_W'(DEPTH) || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_count: got count=%0d full=%b expected %0d 1", count, full, DEPTH);
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    logic [1:0] exp_ack;
    apply_reset();
    @(negedge clk);
    bus.op = 2'b11;
    bus.wdata0 = DATA_W'($urandom_range(0, 255));
    bus.wdata1 = DATA_W'($urandom_range(0, 255));
    bus.req = 2'b11;
    for (int k = 0; k < 200 && n < 6; k++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        exp_ack = (n % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (bus.ack !== exp_ack || bus.err !== 1'b0) begin
          errors++;
          $display("FAIL fairness_grant_%0d: got ack=%b err=%b expected %b 0", n, bus.ack, bus.err, exp_ack);
        end
        n++;
      end
    end
    @(posedge clk);
    #1;
    bus.req = 2'b00;
    checks++;
    if (n !== 6 || count !== CNT_W'(6)) begin
      errors++;
      $display("FAIL fairness_total: got acks=%0d count=%0d expected 6 6", n, count);
    end
  endtask

  task automatic test_timeout();
    int lat, st; logic [1:0] a; logic e; logic [DATA_W-1:0] rd, wd;
    apply_reset();
    send(0, 1'b1, 8'h3C, lat, a, e, rd, st, wd);
    model_hang = 1'b1;
    send(1, 1'b1, 8'h77, lat, a, e, rd, st, wd);
    checks++;
    if (lat !== TIMEOUT + 2 || a !== 2'b10 || e !== 1'b1 || rd !== '0 || st !== 1) begin
      errors++;
      $display("FAIL timeout_ack: got lat=%0d ack=%b err=%b rdata=%h strobes=%0d expected %0d 10 1 00 1",
               lat, a, e, rd, st, TIMEOUT + 2);
    end
    checks++;
    if (busy !== 1'b0 || count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL timeout_after: got busy=%b count=%0d expected 0 1", busy, count);
    end
    model_hang = 1'b0;
    send(0, 1'b0, 8'h00, lat, a, e, rd, st, wd);
    checks++;
    if (rd !== 8'h3C || e !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL timeout_pop: got rdata=%h err=%b count=%0d expected 3c 0 0", rd, e, count);
    end
  endtask

  task automatic test_reset_mid();
    int lat, st; logic [1:0] a; logic e; logic [DATA_W-1:0] rd, wd;
    logic bad = 1'b0;
    apply_reset();
    send(0, 1'b1, 8'h5A, lat, a, e, rd, st, wd);
    model_hang = 1'b1;
    @(negedge clk);
    bus.op[0] = 1'b1; bus.wdata0 = 8'h66; bus.req[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL mid_wait_state: got busy=%b state=%0d expected 1 2", busy, state_dbg);
    end
    rst = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'd0 || count !== '0 || bus.ack !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got state=%0d count=%0d ack=%b expected 0 0 00", state_dbg, count, bus.ack);
    end
    @(negedge clk);
    rst = 1'b0;
    model_hang = 1'b0;
    exp_q.delete();
    late_done = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ack !== 2'b00 || count !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL late_done: got disturbance=%b expected 0", bad);
    end
  endtask

  task automatic test_random();
    int lat, st, r, exp_lat, exp_st; logic [1:0] a, exp_a; logic e, exp_e, push;
    logic [DATA_W-1:0] rd, wd, d, exp_rd;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      r    = $urandom_range(0, 1);
      push = ($urandom_range(0, 99) < 60);
      d    = DATA_W'($urandom_range(0, 255));
      exp_a = (r == 0) ? 2'b01 : 2'b10;
      exp_e = push ? (exp_q.size() == DEPTH) : (exp_q.size() == 0);
      exp_rd = '0;
      if (!exp_e) begin
        if (push) exp_q.push_back(d);
        else      exp_rd = exp_q.pop_back();
      end
      exp_lat = exp_e ? 1 : 3;
      exp_st  = exp_e ? 0 : 1;
      send(r, push, d, lat, a, e, rd, st, wd);
      checks++;
      if (a !== exp_a || e !== exp_e || rd !== exp_rd || lat !== exp_lat || st !== exp_st) begin
        errors++;
        $display("FAIL random_%0d: got ack=%b err=%b rdata=%h lat=%0d strobes=%0d expected %b %b %h %0d %0d",
                 i, a, e, rd, lat, st, exp_a, exp_e, exp_rd, exp_lat, exp_st);
      end
      checks++;
      if (count !== CNT_W'(exp_q.size())) begin
        errors++;
        $display("FAIL random_count_%0d: got %0d expected %0d", i, count, exp_q.size());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req = 2'b00; bus.op = 2'b00; bus.wdata0 = '0; bus.wdata1 = '0;
    pending = 1'b0; model_done = 1'b0; model_hang = 1'b0; late_done = 1'b0;
    pop_hold = '0; bus.stk_rdata = '0;
    test_reset();
    test_single_push();
    test_push_pop();
    test_underflow_overflow();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_access_arbiter.md
Name: stack_access_arbiter

Overview:
- Sequences and shares one 8-bit LIFO stack datapath between two requesters (e.g. host pins and an internal sequencer).
- Arbitrates push/pop requests round-robin and issues single-cycle push/pop strobes to the stack.
- Waits for the stack's completion handshake, tracks occupancy, and rejects overflow/underflow without touching the stack.
- Sits between the requesters and the stack storage block.

Parameters:
- DATA_W, 8, data width of stack entries.
- DEPTH, 16, stack capacity in entries; occupancy counter width is CNT_W = $clog2(DEPTH+1).
- TIMEOUT, 15, maximum WAIT cycles for stk_done before the access is aborted with error.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  per-requester request (valid); bit i = requester i
- op  in  2  per-requester operation: 1 = push, 0 = pop; stable while req[i] high
- wdata0  in  DATA_W  push data, requester 0; stable while req[0] high
- wdata1  in  DATA_W  push data, requester 1; stable while req[1] high
- ack  out  2  one-cycle completion (ready) to the granted requester
- err  out  1  valid with ack: 1 = overflow, underflow or timeout
- rdata  out  DATA_W  pop result, valid with ack; 0 on push or error
- stk_push  out  1  one-cycle push strobe to stack datapath
- stk_pop  out  1  one-cycle pop strobe to stack datapath
- stk_wdata  out  DATA_W  push data to stack, valid with stk_push
- stk_done  in  1  stack completion pulse
- stk_rdata  in  DATA_W  popped data, valid with stk_done
- count  out  CNT_W  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - Clears state to IDLE, count to 0, round-robin pointer to requester 0, and the timeout counter.
  - Clears registered rdata/err/ack.
  - Drives ack = 0, err = 0, rdata = 0, stk_push = 0, stk_pop = 0, stk_wdata = 0, busy = 0, full = 0, empty = 1.
  - Reset mid-access abandons the access with no ack; the stack datapath is reset separately by the same rst.
- Handshake:
  - req[i]/ack[i] is a valid/ready pair; transfer completes on the edge where req[i] & ack[i].
  - req[i] held high after ack is a new request.
  - ack is never asserted to a requester that is not requesting.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is set, pick a winner: the requester named by the rr pointer if requesting, else the other.
  - Latch winner, op and wdata.
  - If push and full, or pop and empty: go to RESP with err = 1 and no stack strobe.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - stk_push = 1 (push) or stk_pop = 1 (pop); stk_wdata = latched data.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - On stk_done: capture stk_rdata (pop only) and go to RESP with err = 0; count increments on push, decrements on pop, on this same edge.
  - Without stk_done: the timeout counter increments. When it reaches TIMEOUT, go to RESP with err = 1, rdata = 0 and count unchanged.
  - stk_done outside WAIT is ignored.
- RESP (one cycle):
  - ack[winner] = 1 with err/rdata valid.
  - rr pointer toggles to the non-winner.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle N → strobe at N+1 → stk_done earliest N+2 → ack at N+3. An error-rejected request acks at N+1.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- count never exceeds DEPTH and never wraps below 0.

Test Plan:
- Reset then a single push by requester 0 (wdata0 = 0xA5; stack model returns done 1 cycle after strobe) → stk_push one cycle with stk_wdata = 0xA5, ack = 01 at N+3, err = 0, count = 1, empty = 0.
- Push 0x11, 0x22, then pop twice from requester 1 → rdata 0x22 then 0x11, err = 0, count returns to 0, empty = 1.
- Pop on empty → ack at N+1 with err = 1, rdata = 0, no stk_pop pulse. Push 17 times with DEPTH = 16 → the 17th gets err = 1, no stk_push, count stays 16, full = 1.
- Both req held high with push ops for 6 transfers → acks alternate 01,10,01,10,01,10 starting with requester 0 after reset, count = 6.
- Stack model never asserts done → after 15 WAIT cycles ack with err = 1, rdata = 0, count unchanged; busy = 0 the cycle after.
- Assert rst during WAIT → next cycle state IDLE, count = 0, no ack issued, late stk_done ignored.
